force_writeback_accumulator: RTL and testbench

//  Downstream consumer of the force writeback arbiter's one-hot grant. Each cycle, muxes the granted

---
 rtl/force_writeback_accumulator_if.sv | 30 +++
 rtl/force_writeback_accumulator.sv | 154 +++++++++++++++
 tb/tb_force_writeback_accumulator.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/force_writeback_accumulator_if.sv
// Bundle between the writeback arbiter / motion-update side and the force accumulator.
// Grant is consumed on an edge iff arbitration_result != 0 and accum_ready = 1; a dump beat is
// transferred on every edge where dump_valid = 1 (no backpressure on the dump stream).
interface force_writeback_accumulator_if #(
  parameter int NUM_REQ = 14,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]          arbitration_result;
  logic [NUM_REQ*ADDR_W-1:0]   wb_addr;
  logic [NUM_REQ*3*DATA_W-1:0] wb_force;
  logic                        accum_ready;
  logic                        dump_start;
  logic                        dump_valid;
  logic [ADDR_W-1:0]           dump_addr;
  logic [3*DATA_W-1:0]         dump_force;
  logic                        dump_done;
  logic                        grant_err;
  logic [2:0]                  fsm_state;

  modport master (
    output arbitration_result, wb_addr, wb_force, dump_start,
    input  accum_ready, dump_valid, dump_addr, dump_force, dump_done, grant_err, fsm_state
  );

  modport slave (
    input  arbitration_result, wb_addr, wb_force, dump_start,
    output accum_ready, dump_valid, dump_addr, dump_force, dump_done, grant_err, fsm_state
  );
endinterface

// File: rtl/force_writeback_accumulator.sv
// Accumulates granted partial forces into a local cache (read-modify-write with same-address
// forwarding) and streams/clears the cache on request.
module force_writeback_accumulator #(
  parameter int NUM_REQ = 14,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 32
) (
  input logic clk,
  input logic rst,
  force_writeback_accumulator_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int FW    = 3*DATA_W;

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_IDLE  = 3'd1,
    S_DRAIN = 3'd2,
    S_DUMP  = 3'd3,
    S_FLUSH = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] cnt;
  logic [FW-1:0]     mem [DEPTH];
  logic [FW-1:0]     rd_data;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [FW-1:0]     wr_data;

  logic              grant_any, grant_multi, accum_ready, accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [FW-1:0]     sel_force;

  logic              p1_v, p2_v, p2_fwd;
  logic [ADDR_W-1:0] p1_addr, p2_addr;
  logic [FW-1:0]     p1_force, p2_force;
  logic [FW-1:0]     sum, base, last_sum;

  logic              dump_v_q, grant_err_q;
  logic [ADDR_W-1:0] dump_addr_q;

  assign grant_any   = |bus.arbitration_result;
  assign grant_multi = |(bus.arbitration_result & (bus.arbitration_result - NUM_REQ'(1)));
  assign accum_ready = (state == S_IDLE);
  assign accept      = grant_any && accum_ready;

  // Scan high-to-low so the lowest set index is the one left standing.
  always_comb begin
    sel_addr  = '0;
    sel_force = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (bus.arbitration_result[i]) begin
        sel_addr  = bus.wb_addr[i*ADDR_W +: ADDR_W];
        sel_force = bus.wb_force[i*FW +: FW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == S_CLEAR || state == S_DUMP) ? cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_CLEAR: if (cnt == ADDR_W'(DEPTH-1)) state_nxt = S_IDLE;
      S_IDLE:  if (bus.dump_start) state_nxt = S_DRAIN;
      S_DRAIN: if (!p1_v && !p2_v) state_nxt = S_DUMP;
      S_DUMP:  if (cnt == ADDR_W'(DEPTH-1)) state_nxt = S_FLUSH;
      S_FLUSH: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_CLEAR;
    endcase
  end

  // Accumulate pipeline: P1 holds the accepted grant while its read is issued, P2 does the add.
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_v   <= 1'b0;
      p2_v   <= 1'b0;
      p2_fwd <= 1'b0;
    end else begin
      p1_v   <= accept;
      p2_v   <= p1_v;
      p2_fwd <= p1_v && p2_v && (p2_addr == p1_addr);
    end
    if (accept) begin
      p1_addr  <= sel_addr;
      p1_force <= sel_force;
    end
    p2_addr  <= p1_addr;
    p2_force <= p1_force;
    if (p2_v) last_sum <= sum;
  end

  // The previous sum is still in flight to memory when the same address follows directly.
  always_comb begin
    sum  = '0;
    base = p2_fwd ? last_sum : rd_data;
    for (int c = 0; c < 3; c++) begin
      sum[c*DATA_W +: DATA_W] = base[c*DATA_W +: DATA_W] + p2_force[c*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = p2_addr;
    wr_data = sum;
    rd_addr = (state == S_DUMP) ? cnt : p1_addr;
    if (state == S_CLEAR || state == S_DUMP) begin
      wr_en   = 1'b1;
      wr_addr = cnt;
      wr_data = '0;
    end else if (p2_v) begin
      wr_en = 1'b1;
    end
  end

  // Read-first: a dump read and the zeroing write of the same entry share one edge.
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dump_v_q    <= 1'b0;
      dump_addr_q <= '0;
      grant_err_q <= 1'b0;
    end else begin
      dump_v_q    <= (state == S_DUMP);
      dump_addr_q <= (state == S_DUMP) ? cnt : dump_addr_q;
      if (grant_any && (!accum_ready || grant_multi)) grant_err_q <= 1'b1;
    end
  end

  assign bus.accum_ready = accum_ready;
  assign bus.dump_valid  = dump_v_q;
  assign bus.dump_addr   = dump_addr_q;
  assign bus.dump_force  = dump_v_q ? rd_data : '0;
  assign bus.dump_done   = (state == S_DONE);
  assign bus.grant_err   = grant_err_q;
  assign bus.fsm_state   = state;
endmodule

// File: tb/tb_force_writeback_accumulator.sv
// Directed bench: vector table for the accumulate path, hand sequences for dump/reset corners.
module tb_force_writeback_accumulator;
  localparam int NUM_REQ = 14;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 128;
  localparam int FW      = 3*DATA_W;
  localparam int NVEC    = 17;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  force_writeback_accumulator_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  force_writeback_accumulator #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [NUM_REQ-1:0] grant;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  x, y, z;
    logic               exp_err;
  } vec_t;

  vec_t          vecs [NVEC];
  logic [FW-1:0] exp_mem [DEPTH];
  logic [FW-1:0] exp_q [$];
  int            n_vec;
  int            n_miss;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_add(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] x,
                           input logic [DATA_W-1:0] y, input logic [DATA_W-1:0] z);
    logic [DATA_W-1:0] ox, oy, oz;
    {oz, oy, ox} = exp_mem[a];
    exp_mem[a] = {oz + z, oy + y, ox + x};
  endtask

  // Non-winning requesters carry random decoy data so a wrong mux choice corrupts the cache.
  task automatic drive_grant(input logic [NUM_REQ-1:0] g, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y,
                             input logic [DATA_W-1:0] z);
    int win;
    win = -1;
    for (int i = NUM_REQ-1; i >= 0; i--) if (g[i]) win = i;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.wb_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, DEPTH-1));
      bus.wb_force[i*FW +: FW]        = {$urandom(), $urandom(), $urandom()};
    end
    if (win >= 0) begin
      bus.wb_addr[win*ADDR_W +: ADDR_W] = a;
      bus.wb_force[win*FW +: FW]        = {z, y, x};
    end
    bus.arbitration_result = g;
  endtask

  task automatic do_reset();
    int  cyc;
    logic stray;
    rst = 1'b1;
    bus.arbitration_result = '0;
    bus.dump_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready",     bus.accum_ready, 0);
    check("rst_dump_valid", bus.dump_valid, 0);
    check("rst_dump_done", bus.dump_done, 0);
    check("rst_grant_err", bus.grant_err, 0);
    cyc = 0;
    stray = 1'b0;
    while (!bus.accum_ready && cyc < 1000) begin
      if (bus.dump_done || bus.dump_valid) stray = 1'b1;
      cyc++;
      @(negedge clk);
    end
    check("clear_cycles", cyc, 128);
    check("clear_no_dump_out", stray, 0);
    for (int k = 0; k < DEPTH; k++) exp_mem[k] = '0;
  endtask

  // Called on a negedge in IDLE. stop_at >= 0 returns right after that many beats were seen;
  // inject_at >= 0 drives one grant (which must be dropped) after that many beats.
  task automatic run_dump(input int stop_at, input int inject_at);
    int            beat, cyc, want;
    logic          injected;
    logic [FW-1:0] e;
    for (int k = 0; k < DEPTH; k++) begin
      exp_q.push_back(exp_mem[k]);
      exp_mem[k] = '0;
    end
    bus.dump_start = 1'b1;
    @(negedge clk);
    bus.dump_start = 1'b0;
    beat = 0;
    cyc = 0;
    injected = 1'b0;
    forever begin
      bus.arbitration_result = '0;
      if (bus.dump_valid) begin
        e = exp_q.pop_front();
        check("dump_addr", bus.dump_addr, beat[ADDR_W-1:0]);
        check("dump_force", bus.dump_force, e);
        check("dump_done_early", bus.dump_done, 0);
        beat++;
      end else if (beat > 0 && beat < DEPTH) begin
        check("dump_contiguous", bus.dump_valid, 1);
      end
      if (beat == inject_at && !injected) begin
        drive_grant(14'h0010, 7'd50, 32'd9, 32'd9, 32'd9);
        injected = 1'b1;
      end
      if (beat >= DEPTH || beat == stop_at || cyc >= 600) break;
      @(negedge clk);
      cyc++;
    end
    want = (stop_at >= 0) ? stop_at : DEPTH;
    check("dump_beats", beat, want);
    if (beat == DEPTH) begin
      @(negedge clk);
      check("dump_done_pulse", bus.dump_done, 1);
      check("dump_valid_off", bus.dump_valid, 0);
      @(negedge clk);
      check("dump_done_clear", bus.dump_done, 0);
      check("ready_after_dump", bus.accum_ready, 1);
    end
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_miss = 0;
    bus.arbitration_result = '0;
    bus.wb_addr = '0;
    bus.wb_force = '0;
    bus.dump_start = 1'b0;

    vecs[0]  = '{14'h0008, 7'd5,   32'd1,         32'd2,         32'd3,         1'b0};
    vecs[1]  = '{14'h0001, 7'd9,   32'd10,        32'd0,         32'd0,         1'b0};
    vecs[2]  = '{14'h0002, 7'd9,   32'd20,        32'd0,         32'd0,         1'b0};
    vecs[3]  = '{14'h0004, 7'd9,   32'd30,        32'd0,         32'd0,         1'b0};
    vecs[4]  = '{14'h0001, 7'd9,   32'd40,        32'd0,         32'd0,         1'b0};
    vecs[5]  = '{14'h0000, 7'd0,   32'd0,         32'd0,         32'd0,         1'b0};
    vecs[6]  = '{14'h0010, 7'd2,   32'h7FFFFFFF,  32'd5,         32'hFFFFFFFF,  1'b0};
    vecs[7]  = '{14'h0020, 7'd2,   32'd1,         32'hFFFFFFFD,  32'd1,         1'b0};
    vecs[8]  = '{14'h2000, 7'd20,  32'd100,       32'd200,       32'd300,       1'b0};
    vecs[9]  = '{14'h0000, 7'd0,   32'd0,         32'd0,         32'd0,         1'b0};
    vecs[10] = '{14'h0040, 7'd20,  32'd1,         32'd1,         32'd1,         1'b0};
    vecs[11] = '{14'h0000, 7'd0,   32'd0,         32'd0,         32'd0,         1'b0};
    vecs[12] = '{14'h0080, 7'd20,  32'd2,         32'd2,         32'd2,         1'b0};
    vecs[13] = '{14'h0100, 7'd127, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0};
    vecs[14] = '{14'h0200, 7'd0,   32'd8,         32'd9,         32'd10,        1'b0};
    vecs[15] = '{14'h0400, 7'd127, 32'd2,         32'd0,         32'd0,         1'b0};
    vecs[16] = '{14'h0006, 7'd30,  32'd5,         32'd6,         32'd7,         1'b1};

    // Power-up clear, then an immediate dump of an all-zero cache.
    repeat (2) @(negedge clk);
    do_reset();
    run_dump(-1, -1);

    // Table: one grant per cycle, grant_err checked after each.
    for (int i = 0; i < NVEC; i++) begin
      drive_grant(vecs[i].grant, vecs[i].addr, vecs[i].x, vecs[i].y, vecs[i].z);
      if (vecs[i].grant != '0) model_add(vecs[i].addr, vecs[i].x, vecs[i].y, vecs[i].z);
      @(negedge clk);
      check($sformatf("vec%0d_grant_err", i), bus.grant_err, vecs[i].exp_err);
      check($sformatf("vec%0d_ready", i), bus.accum_ready, 1);
    end

    // Grant on the same edge as dump_start must still land before the dump reads it.
    drive_grant(14'h0008, 7'd60, 32'd4, 32'd4, 32'd4);
    model_add(7'd60, 32'd4, 32'd4, 32'd4);
    run_dump(-1, -1);
    check("grant_err_sticky", bus.grant_err, 1);

    // Back-to-back second dump sees a cleared cache.
    run_dump(-1, -1);

    // Grant during DUMP is dropped and flags an error.
    do_reset();
    run_dump(-1, 10);
    check("dump_grant_err", bus.grant_err, 1);
    run_dump(-1, -1);

    // Reset in the middle of a dump: no dump_done, CLEAR re-runs, cache ends up empty.
    do_reset();
    drive_grant(14'h0001, 7'd100, 32'd7, 32'd8, 32'd9);
    model_add(7'd100, 32'd7, 32'd8, 32'd9);
    @(negedge clk);
    bus.arbitration_result = '0;
    repeat (3) @(negedge clk);
    run_dump(40, -1);
    do_reset();
    run_dump(-1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
